alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 64-bit ALU between two requesters, for example the integer execute path and the branch-compare path. It accepts one operation at a time over a valid/ready request handshake, latches the operands, runs the ALU for one cycle and holds the registered result until the owning requester accepts it over a valid/ready response handshake. It instantiates the ALU internally and is the only block that drives the ALU's inputs.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_arbiter_if.sv | 25 ++
 rtl/alu_arbiter_alu.sv | 30 +++
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter/sequencer.
package alu_pkg;

  localparam int ALU_W    = 64;
  localparam int ALU_NREQ = 2;

  localparam logic [2:0] ALU_OP_SUB = 3'b000;
  localparam logic [2:0] ALU_OP_AND = 3'b001;
  localparam logic [2:0] ALU_OP_OR  = 3'b011;
  localparam logic [2:0] ALU_OP_ADD = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arbState_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters and the ALU arbiter.
interface alu_arbiter_if;

  logic [alu_pkg::ALU_NREQ-1:0]                    reqValid_in;
  logic [alu_pkg::ALU_NREQ-1:0]                    reqReady_out;
  logic [alu_pkg::ALU_NREQ-1:0][alu_pkg::ALU_W-1:0] operand1_in;
  logic [alu_pkg::ALU_NREQ-1:0][alu_pkg::ALU_W-1:0] operand2_in;
  logic [alu_pkg::ALU_NREQ-1:0][2:0]               aluOpcode_in;
  logic [alu_pkg::ALU_NREQ-1:0]                    respValid_out;
  logic [alu_pkg::ALU_NREQ-1:0]                    respReady_in;
  logic [alu_pkg::ALU_W-1:0]                       result_out;
  logic                                            zeroFlag_out;
  logic                                            busy_out;

  modport master (
    output reqValid_in, operand1_in, operand2_in, aluOpcode_in, respReady_in,
    input  reqReady_out, respValid_out, result_out, zeroFlag_out, busy_out
  );

  modport slave (
    input  reqValid_in, operand1_in, operand2_in, aluOpcode_in, respReady_in,
    output reqReady_out, respValid_out, result_out, zeroFlag_out, busy_out
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 64-bit ALU: SUB/AND/OR/ADD (unknown codes add); zero flag always
// taken from the adder, which subtracts for SUB, AND and OR.
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [2:0]       op,
  output logic [ALU_W-1:0] result,
  output logic             zero
);

  logic             sub;
  logic [ALU_W-1:0] b_mux;
  logic [ALU_W-1:0] sum;

  always_comb begin
    sub    = (op == ALU_OP_SUB) || (op == ALU_OP_AND) || (op == ALU_OP_OR);
    b_mux  = sub ? ~b : b;
    sum    = a + b_mux + {{(ALU_W-1){1'b0}}, sub};
    zero   = ~|sum;
    result = sum;
    case (op)
      ALU_OP_AND: result = a & b;
      ALU_OP_OR:  result = a | b;
      default:    result = sum;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters; accept -> EXEC -> RESP,
// response two cycles after accept, held until the owner takes it (retire can overlap next accept).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int NUM_REQ = 2
) (
  input  logic          clk_in,
  input  logic          reset_in,
  alu_arbiter_if.slave  bus
);

  arbState_t            state;
  logic                 owner;
  logic                 last_grant;
  logic [WIDTH-1:0]     op1_q;
  logic [WIDTH-1:0]     op2_q;
  logic [2:0]           opc_q;
  logic [NUM_REQ-1:0]   resp_vld_q;
  logic [WIDTH-1:0]     result_q;
  logic                 zero_q;
  logic                 busy_q;

  logic [NUM_REQ-1:0]   valid;
  logic [NUM_REQ-1:0]   grant;
  logic                 win;
  logic                 retire;
  logic                 can_accept;
  logic                 accept;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_zero;

  // A lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    valid      = bus.reqValid_in;
    retire     = (state == RESP) && resp_vld_q[owner] && bus.respReady_in[owner];
    can_accept = !reset_in && ((state == IDLE) || retire);
    win        = (valid == 2'b11) ? ~last_grant : valid[1];
    grant      = '0;
    if (can_accept && valid[win]) begin
      grant[win] = 1'b1;
    end
    accept     = |grant;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      op1_q      <= '0;
      op2_q      <= '0;
      opc_q      <= '0;
      resp_vld_q <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if (accept) begin
        op1_q      <= bus.operand1_in[win];
        op2_q      <= bus.operand2_in[win];
        opc_q      <= bus.aluOpcode_in[win];
        owner      <= win;
        last_grant <= win;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= EXEC;
            busy_q <= 1'b1;
          end
        end
        EXEC: begin
          result_q   <= alu_res;
          zero_q     <= alu_zero;
          resp_vld_q <= owner ? 2'b10 : 2'b01;
          state      <= RESP;
        end
        RESP: begin
          if (retire) begin
            resp_vld_q <= '0;
            state      <= accept ? EXEC : IDLE;
            busy_q     <= accept;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  alu_arbiter_alu u_alu (
    .a      (op1_q),
    .b      (op2_q),
    .op     (opc_q),
    .result (alu_res),
    .zero   (alu_zero)
  );

  assign bus.reqReady_out  = grant;
  assign bus.respValid_out = resp_vld_q;
  assign bus.result_out    = result_q;
  assign bus.zeroFlag_out  = zero_q;
  assign bus.busy_out      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single ops, round-robin ties,
// response backpressure with back-to-back accept, unknown opcode, reset mid-response.
module tb_alu_arbiter;

  logic clk_in;
  logic reset_in;
  int   checks;
  int   errors;

  alu_arbiter_if bus ();

  alu_arbiter #(.WIDTH(64), .NUM_REQ(2)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_req(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] op);
    bus.operand1_in[i]  = a;
    bus.operand2_in[i]  = b;
    bus.aluOpcode_in[i] = op;
    bus.reqValid_in[i]  = 1'b1;
  endtask

  task automatic test_reset();
    reset_in         = 1'b1;
    bus.reqValid_in  = 2'b00;
    bus.respReady_in = 2'b00;
    bus.operand1_in  = '0;
    bus.operand2_in  = '0;
    bus.aluOpcode_in = '0;
    #2;
    checks++; if (bus.respValid_out !== 2'b00) begin errors++; $display("FAIL rst_respValid got %b exp 00", bus.respValid_out); end
    checks++; if (bus.reqReady_out !== 2'b00) begin errors++; $display("FAIL rst_reqReady got %b exp 00", bus.reqReady_out); end
    checks++; if (bus.result_out !== 64'd0) begin errors++; $display("FAIL rst_result got %h exp 0", bus.result_out); end
    checks++; if (bus.zeroFlag_out !== 1'b0 || bus.busy_out !== 1'b0) begin errors++; $display("FAIL rst_flags got z=%b b=%b exp 0 0", bus.zeroFlag_out, bus.busy_out); end
    @(negedge clk_in);
    reset_in = 1'b0;
    tick();
    checks++; if (bus.reqReady_out !== 2'b00) begin errors++; $display("FAIL idle_noreq_ready got %b exp 00", bus.reqReady_out); end
  endtask

  task automatic test_single();
    bus.respReady_in = 2'b11;
    drive_req(0, 64'd5, 64'd7, 3'b111);
    #1;
    checks++; if (bus.reqReady_out !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", bus.reqReady_out); end
    tick();
    bus.reqValid_in = 2'b00;
    #1;
    checks++; if (bus.busy_out !== 1'b1 || bus.respValid_out !== 2'b00 || bus.reqReady_out !== 2'b00) begin errors++; $display("FAIL single_exec got b=%b rv=%b rr=%b exp 1 00 00", bus.busy_out, bus.respValid_out, bus.reqReady_out); end
    tick();
    checks++; if (bus.respValid_out !== 2'b01) begin errors++; $display("FAIL single_respValid got %b exp 01", bus.respValid_out); end
    checks++; if (bus.result_out !== 64'd12 || bus.zeroFlag_out !== 1'b0) begin errors++; $display("FAIL single_result got %h z=%b exp c z=0", bus.result_out, bus.zeroFlag_out); end
    tick();
    checks++; if (bus.respValid_out !== 2'b00 || bus.busy_out !== 1'b0) begin errors++; $display("FAIL single_retire got rv=%b b=%b exp 00 0", bus.respValid_out, bus.busy_out); end
  endtask

  task automatic test_sub_zero();
    drive_req(1, 64'h10, 64'h10, 3'b000);
    #1;
    checks++; if (bus.reqReady_out !== 2'b10) begin errors++; $display("FAIL sub_ready got %b exp 10", bus.reqReady_out); end
    tick();
    bus.reqValid_in = 2'b00;
    tick();
    checks++; if (bus.respValid_out !== 2'b10) begin errors++; $display("FAIL sub_respValid got %b exp 10", bus.respValid_out); end
    checks++; if (bus.result_out !== 64'd0 || bus.zeroFlag_out !== 1'b1) begin errors++; $display("FAIL sub_result got %h z=%b exp 0 z=1", bus.result_out, bus.zeroFlag_out); end
    tick();
  endtask

  task automatic test_tie_round_robin();
    logic [1:0]  exp_grant;
    logic [63:0] exp_res;
    drive_req(0, 64'hF0, 64'h3C, 3'b001);
    drive_req(1, 64'hF0, 64'h0F, 3'b011);
    for (int k = 0; k < 4; k++) begin
      exp_grant = (k % 2 == 1) ? 2'b10 : 2'b01;
      exp_res   = (k % 2 == 1) ? 64'hFF : 64'h30;
      #1;
      checks++; if (bus.reqReady_out !== exp_grant) begin errors++; $display("FAIL tie_grant%0d got %b exp %b", k, bus.reqReady_out, exp_grant); end
      tick();
      checks++; if (bus.reqReady_out !== 2'b00) begin errors++; $display("FAIL tie_exec_ready%0d got %b exp 00", k, bus.reqReady_out); end
      tick();
      checks++; if (bus.respValid_out !== exp_grant || bus.result_out !== exp_res || bus.zeroFlag_out !== 1'b0) begin errors++; $display("FAIL tie_resp%0d got rv=%b res=%h z=%b exp rv=%b res=%h z=0", k, bus.respValid_out, bus.result_out, bus.zeroFlag_out, exp_grant, exp_res); end
    end
    bus.reqValid_in = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    bus.respReady_in = 2'b00;
    drive_req(0, 64'd1, 64'd1, 3'b111);
    drive_req(1, 64'd2, 64'd2, 3'b111);
    #1;
    checks++; if (bus.reqReady_out !== 2'b01) begin errors++; $display("FAIL bp_first_ready got %b exp 01", bus.reqReady_out); end
    tick();
    bus.reqValid_in[0] = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.respValid_out !== 2'b01 || bus.result_out !== 64'd2 || bus.busy_out !== 1'b1 || bus.reqReady_out !== 2'b00) begin errors++; $display("FAIL bp_hold%0d got rv=%b res=%h b=%b rr=%b exp 01 2 1 00", c, bus.respValid_out, bus.result_out, bus.busy_out, bus.reqReady_out); end
      tick();
    end
    bus.respReady_in = 2'b01;
    #1;
    checks++; if (bus.reqReady_out !== 2'b10) begin errors++; $display("FAIL bp_retire_ready got %b exp 10", bus.reqReady_out); end
    tick();
    bus.reqValid_in[1] = 1'b0;
    checks++; if (bus.respValid_out !== 2'b00 || bus.busy_out !== 1'b1) begin errors++; $display("FAIL bp_b2b_exec got rv=%b b=%b exp 00 1", bus.respValid_out, bus.busy_out); end
    tick();
    checks++; if (bus.respValid_out !== 2'b10 || bus.result_out !== 64'd4) begin errors++; $display("FAIL bp_second_resp got rv=%b res=%h exp 10 4", bus.respValid_out, bus.result_out); end
    tick();
    checks++; if (bus.respValid_out !== 2'b10) begin errors++; $display("FAIL bp_nonowner_ready got rv=%b exp 10", bus.respValid_out); end
    bus.respReady_in = 2'b11;
    tick();
    checks++; if (bus.respValid_out !== 2'b00 || bus.busy_out !== 1'b0) begin errors++; $display("FAIL bp_final_retire got rv=%b b=%b exp 00 0", bus.respValid_out, bus.busy_out); end
  endtask

  task automatic test_undefined_op();
    drive_req(0, 64'd3, 64'd4, 3'b010);
    tick();
    bus.reqValid_in = 2'b00;
    tick();
    checks++; if (bus.respValid_out !== 2'b01 || bus.result_out !== 64'd7 || bus.zeroFlag_out !== 1'b0) begin errors++; $display("FAIL undef_op got rv=%b res=%h z=%b exp 01 7 0", bus.respValid_out, bus.result_out, bus.zeroFlag_out); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.respReady_in = 2'b00;
    drive_req(1, 64'd9, 64'd9, 3'b111);
    #1;
    checks++; if (bus.reqReady_out !== 2'b10) begin errors++; $display("FAIL rm_ready got %b exp 10", bus.reqReady_out); end
    tick();
    tick();
    checks++; if (bus.respValid_out !== 2'b10 || bus.result_out !== 64'd18) begin errors++; $display("FAIL rm_resp got rv=%b res=%h exp 10 12", bus.respValid_out, bus.result_out); end
    drive_req(0, 64'h100, 64'h23, 3'b111);
    #2;
    reset_in = 1'b1;
    #1;
    checks++; if (bus.respValid_out !== 2'b00 || bus.result_out !== 64'd0 || bus.busy_out !== 1'b0 || bus.reqReady_out !== 2'b00) begin errors++; $display("FAIL rm_async got rv=%b res=%h b=%b rr=%b exp 00 0 0 00", bus.respValid_out, bus.result_out, bus.busy_out, bus.reqReady_out); end
    @(negedge clk_in);
    reset_in = 1'b0;
    bus.respReady_in = 2'b11;
    #1;
    checks++; if (bus.reqReady_out !== 2'b01) begin errors++; $display("FAIL rm_tie_after_reset got %b exp 01", bus.reqReady_out); end
    tick();
    bus.reqValid_in = 2'b00;
    tick();
    checks++; if (bus.respValid_out !== 2'b01 || bus.result_out !== 64'h123) begin errors++; $display("FAIL rm_post_resp got rv=%b res=%h exp 01 123", bus.respValid_out, bus.result_out); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_sub_zero();
    test_tie_round_robin();
    test_backpressure();
    test_undefined_op();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
